// File: rtl/rbt_hdr_rr_arbiter_pkg.sv
// Shared parser constants for the proto-header arbitration stage: default
// stream count, header/PHV sizing, PHV field offsets and the index-width helper.
package rbt_hdr_rr_arbiter_pkg;

    // Default number of proto-header streams feeding the parser chain.
    localparam int RBT_PORTS        = 4;
    localparam int RBT_HEADER_WIDTH = 2048;
    localparam int RBT_PHV_WIDTH    = 408;

    // Bit offsets of the main fields inside the packet header vector.
    localparam int PHV_ETH_DST_OFF  = 0;
    localparam int PHV_ETH_SRC_OFF  = 48;
    localparam int PHV_ETH_TYPE_OFF = 96;
    localparam int PHV_IP_SRC_OFF   = 112;
    localparam int PHV_IP_DST_OFF   = 144;
    localparam int PHV_IP_PROTO_OFF = 176;
    localparam int PHV_L4_SPORT_OFF = 184;
    localparam int PHV_L4_DPORT_OFF = 200;
    localparam int PHV_META_OFF     = 216;

    // Index width for n items, never narrower than one bit so a
    // single-port build still has a legal port-index field.
    function automatic int rbt_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rbt_rr_arb.sv
// Wrap-around priority search: picks the first requester strictly after
// last_ptr, wrapping past the top port back to port 0.
module rbt_rr_arb
    import rbt_hdr_rr_arbiter_pkg::*;
#(
    parameter int PORTS = RBT_PORTS,
    parameter int IDX_W = rbt_clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic [PORTS-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Walk the ports in priority order starting after last_ptr; the first hit wins.
    always_comb begin
        int cand;
        logic [IDX_W-1:0] cand_idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 1; i <= PORTS; i++) begin
            cand = int'(last_ptr) + i;
            if (cand >= PORTS) begin
                cand = cand - PORTS;
            end
            cand_idx = IDX_W'(cand);
            if (!grant_valid && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                grant_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rbt_hdr_rr_arbiter.sv
// Round-robin merge of several proto-header streams into a single parser
// chain input. One output register; a new header is accepted whenever that
// register is empty or being drained in the same cycle.
module rbt_hdr_rr_arbiter
    import rbt_hdr_rr_arbiter_pkg::*;
#(
    parameter  int PORTS        = RBT_PORTS,
    parameter  int HEADER_WIDTH = RBT_HEADER_WIDTH,
    parameter  int PHV_WIDTH    = RBT_PHV_WIDTH,
    localparam int IDX_W        = rbt_clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS-1:0]            cfg_port_en,
    input  logic [PORTS-1:0]            s_hdr_valid,
    output logic [PORTS-1:0]            s_hdr_ready,
    input  logic [PORTS*HEADER_WIDTH-1:0] s_hdr_data,
    input  logic [PORTS*16-1:0]         s_hdr_length,
    input  logic [PORTS*PHV_WIDTH-1:0]  s_hdr_phv,
    output logic                        m_hdr_valid,
    input  logic                        m_hdr_ready,
    output logic [HEADER_WIDTH-1:0]     m_hdr_data,
    output logic [15:0]                 m_hdr_length,
    output logic [PHV_WIDTH-1:0]        m_hdr_phv,
    output logic [IDX_W-1:0]            m_hdr_port
);

    logic [IDX_W-1:0]        last_ptr;
    logic [PORTS-1:0]        req;
    logic [PORTS-1:0]        grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_valid;
    logic                    slot_free;
    logic                    load;
    logic [HEADER_WIDTH-1:0] sel_data;
    logic [15:0]             sel_length;
    logic [PHV_WIDTH-1:0]    sel_phv;

    // Disabled ports never reach the priority search.
    assign req       = s_hdr_valid & cfg_port_en;
    assign slot_free = !m_hdr_valid || m_hdr_ready;

    rbt_rr_arb #(
        .PORTS (PORTS),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .req         (req),
        .last_ptr    (last_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // A grant only exists for a valid port, so handshake and load coincide;
    // reset suppresses both so nothing is half-accepted.
    assign load        = slot_free && grant_valid && !rst;
    assign s_hdr_ready = load ? grant : '0;

    assign sel_data   = s_hdr_data[int'(grant_idx)*HEADER_WIDTH +: HEADER_WIDTH];
    assign sel_length = s_hdr_length[int'(grant_idx)*16 +: 16];
    assign sel_phv    = s_hdr_phv[int'(grant_idx)*PHV_WIDTH +: PHV_WIDTH];

    // Output register and round-robin pointer: load on transfer, drop valid on a bare drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_hdr_valid  <= 1'b0;
            m_hdr_data   <= '0;
            m_hdr_length <= '0;
            m_hdr_phv    <= '0;
            m_hdr_port   <= '0;
            last_ptr     <= IDX_W'(PORTS - 1);
        end else if (load) begin
            m_hdr_valid  <= 1'b1;
            m_hdr_data   <= sel_data;
            m_hdr_length <= sel_length;
            m_hdr_phv    <= sel_phv;
            m_hdr_port   <= grant_idx;
            last_ptr     <= grant_idx;
        end else if (m_hdr_ready) begin
            m_hdr_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rbt_hdr_rr_arbiter.sv
// Self-checking bench for rbt_hdr_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural round-robin model.
module tb_rbt_hdr_rr_arbiter;
    import rbt_hdr_rr_arbiter_pkg::*;

    localparam int PORTS = 4;
    localparam int HW    = 2048;
    localparam int PW    = 408;
    localparam int IW    = rbt_clog2(PORTS);

    logic                  clk;
    logic                  rst;
    logic [PORTS-1:0]      cfg_port_en;
    logic [PORTS-1:0]      s_hdr_valid;
    logic [PORTS-1:0]      s_hdr_ready;
    logic [PORTS*HW-1:0]   s_hdr_data;
    logic [PORTS*16-1:0]   s_hdr_length;
    logic [PORTS*PW-1:0]   s_hdr_phv;
    logic                  m_hdr_valid;
    logic                  m_hdr_ready;
    logic [HW-1:0]         m_hdr_data;
    logic [15:0]           m_hdr_length;
    logic [PW-1:0]         m_hdr_phv;
    logic [IW-1:0]         m_hdr_port;

    logic [HW-1:0] hdr_data [PORTS];
    logic [15:0]   hdr_len  [PORTS];
    logic [PW-1:0] hdr_phv  [PORTS];

    int tests_run;
    int fail_count;

    // Reference model state: the output slot contents and the last granted port.
    logic          mv;
    logic [HW-1:0] md;
    logic [15:0]   ml;
    logic [PW-1:0] mp;
    int            mport;
    int            mlast;

    rbt_hdr_rr_arbiter #(
        .PORTS        (PORTS),
        .HEADER_WIDTH (HW),
        .PHV_WIDTH    (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_port_en  (cfg_port_en),
        .s_hdr_valid  (s_hdr_valid),
        .s_hdr_ready  (s_hdr_ready),
        .s_hdr_data   (s_hdr_data),
        .s_hdr_length (s_hdr_length),
        .s_hdr_phv    (s_hdr_phv),
        .m_hdr_valid  (m_hdr_valid),
        .m_hdr_ready  (m_hdr_ready),
        .m_hdr_data   (m_hdr_data),
        .m_hdr_length (m_hdr_length),
        .m_hdr_phv    (m_hdr_phv),
        .m_hdr_port   (m_hdr_port)
    );

    for (genvar p = 0; p < PORTS; p++) begin : g_pack
        assign s_hdr_data[p*HW +: HW]   = hdr_data[p];
        assign s_hdr_length[p*16 +: 16] = hdr_len[p];
        assign s_hdr_phv[p*PW +: PW]    = hdr_phv[p];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        int w;
        tests_run++;
        assert (obs === exp) else begin
            fail_count++;
            w = 0;
            while (w < HW/32 - 1 && obs[w*32 +: 32] === exp[w*32 +: 32]) w++;
            $error("FAIL %s: word %0d observed %h expected %h", tag, w, obs[w*32 +: 32], exp[w*32 +: 32]);
        end
    endtask

    task automatic randomize_port(input int p);
        logic [HW-1:0] tmp;
        for (int w = 0; w < HW/32; w++) hdr_data[p][w*32 +: 32] = $urandom;
        for (int w = 0; w < HW/32; w++) tmp[w*32 +: 32] = $urandom;
        hdr_phv[p] = tmp[PW-1:0];
        hdr_len[p] = 16'($urandom_range(14, 256));
    endtask

    task automatic apply_stimulus(input logic [PORTS-1:0] v, input logic [PORTS-1:0] en,
                                  input logic rdy, input logic r);
        s_hdr_valid = v;
        cfg_port_en = en;
        m_hdr_ready = rdy;
        rst         = r;
    endtask

    // Winner = enabled valid port with the smallest forward distance past the last grant.
    function automatic int model_pick();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = PORTS + 1;
        for (int p = 0; p < PORTS; p++) begin
            if (s_hdr_valid[p] && cfg_port_en[p]) begin
                d = (p - mlast - 1 + 2*PORTS) % PORTS;
                if (d < bestd) begin
                    bestd = d;
                    best  = p;
                end
            end
        end
        return best;
    endfunction

    task automatic check_output();
        check_val("m_hdr_valid", 64'(m_hdr_valid), 64'(mv));
        check_val("m_hdr_port", 64'(m_hdr_port), 64'(mport));
        check_val("m_hdr_length", 64'(m_hdr_length), 64'(ml));
        check_wide("m_hdr_data", m_hdr_data, md);
        check_wide("m_hdr_phv", HW'(m_hdr_phv), HW'(mp));
    endtask

    // One clock: check the combinational accept, advance model and DUT, check outputs.
    task automatic cycle();
        int g;
        logic [PORTS-1:0] exp_ready;
        #1;
        g = (!rst && (!mv || m_hdr_ready)) ? model_pick() : -1;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_val("s_hdr_ready", 64'(s_hdr_ready), 64'(exp_ready));
        @(posedge clk);
        if (rst) begin
            mv = 1'b0; md = '0; ml = '0; mp = '0; mport = 0; mlast = PORTS - 1;
        end else if (g >= 0) begin
            mv = 1'b1; md = hdr_data[g]; ml = hdr_len[g]; mp = hdr_phv[g];
            mport = g; mlast = g;
        end else if (m_hdr_ready) begin
            mv = 1'b0;
        end
        #1;
        check_output();
    endtask

    initial begin
        int exp_rr[5];
        int exp_mask[4];
        logic [HW-1:0] snap_data;
        logic [PW-1:0] snap_phv;
        logic [IW-1:0] snap_port;
        logic [15:0]   snap_len;

        tests_run  = 0;
        fail_count = 0;
        mv = 1'b0; md = '0; ml = '0; mp = '0; mport = 0; mlast = PORTS - 1;
        exp_rr   = '{0, 1, 2, 3, 0};
        exp_mask = '{0, 1, 3, 0};
        for (int p = 0; p < PORTS; p++) randomize_port(p);

        // Reset state.
        apply_stimulus('0, '1, 1'b1, 1'b1);
        cycle();
        cycle();
        check_val("reset_valid", 64'(m_hdr_valid), 64'd0);
        check_val("reset_port", 64'(m_hdr_port), 64'd0);
        check_val("reset_length", 64'(m_hdr_length), 64'd0);

        // All four ports valid, sink always ready: strict rotation from port 0.
        apply_stimulus(4'hF, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_val("rr_sequence", 64'(m_hdr_port), 64'(exp_rr[i]));
        end

        // Lone request on port 2 appears one cycle later, bit-exact.
        apply_stimulus('0, 4'hF, 1'b1, 1'b1);
        cycle();
        randomize_port(2);
        hdr_len[2] = 16'd64;
        apply_stimulus(4'b0100, 4'hF, 1'b1, 1'b0);
        cycle();
        check_val("single_valid", 64'(m_hdr_valid), 64'd1);
        check_val("single_port", 64'(m_hdr_port), 64'd2);
        check_val("single_length", 64'(m_hdr_length), 64'd64);
        check_wide("single_data", m_hdr_data, hdr_data[2]);
        check_wide("single_phv", HW'(m_hdr_phv), HW'(hdr_phv[2]));

        // Backpressure: held output stays frozen and nothing is accepted.
        snap_data = m_hdr_data; snap_phv = m_hdr_phv; snap_port = m_hdr_port; snap_len = m_hdr_length;
        apply_stimulus(4'hF, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_val("hold_ready", 64'(s_hdr_ready), 64'd0);
            check_val("hold_port", 64'(m_hdr_port), 64'(snap_port));
            check_val("hold_length", 64'(m_hdr_length), 64'(snap_len));
            check_wide("hold_data", m_hdr_data, snap_data);
            check_wide("hold_phv", HW'(m_hdr_phv), HW'(snap_phv));
        end
        apply_stimulus('0, 4'hF, 1'b1, 1'b0);
        cycle();
        check_val("drain_valid", 64'(m_hdr_valid), 64'd0);

        // Port 2 masked: it is skipped in the rotation.
        apply_stimulus('0, 4'hF, 1'b1, 1'b1);
        cycle();
        apply_stimulus(4'hF, 4'b1011, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_val("mask_sequence", 64'(m_hdr_port), 64'(exp_mask[i]));
        end

        // Reset while holding a header discards it; port 0 wins afterwards.
        apply_stimulus(4'hF, 4'hF, 1'b0, 1'b0);
        cycle();
        check_val("pre_reset_valid", 64'(m_hdr_valid), 64'd1);
        apply_stimulus(4'hF, 4'hF, 1'b0, 1'b1);
        cycle();
        check_val("midreset_valid", 64'(m_hdr_valid), 64'd0);
        apply_stimulus(4'hF, 4'hF, 1'b1, 1'b0);
        cycle();
        check_val("post_reset_port", 64'(m_hdr_port), 64'd0);

        // Wrap-around: last grant on port 3, requests on 1 and 3 -> port 1.
        apply_stimulus('0, 4'hF, 1'b1, 1'b1);
        cycle();
        apply_stimulus(4'b1000, 4'hF, 1'b1, 1'b0);
        cycle();
        check_val("wrap_setup_port", 64'(m_hdr_port), 64'd3);
        apply_stimulus(4'b1010, 4'hF, 1'b1, 1'b0);
        cycle();
        check_val("wrap_port", 64'(m_hdr_port), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            randomize_port(int'($urandom_range(0, PORTS - 1)));
            apply_stimulus(PORTS'($urandom),
                           ($urandom_range(0, 3) == 0) ? PORTS'($urandom) : '1,
                           ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 63) == 0));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
